// File: rtl/gpio_scanner_pkg.sv
// Shared address map, scan FSM states and debounce sizing for the GPIO scanner.
package gpio_map_pkg;

  localparam logic [8:0] ADDR_BTN   = 9'd503;
  localparam logic [8:0] ADDR_SW_L  = 9'd504;
  localparam logic [8:0] ADDR_SW_H  = 9'd505;
  localparam logic [8:0] ADDR_LED_L = 9'd506;
  localparam logic [8:0] ADDR_LED_H = 9'd507;
  localparam logic [8:0] ADDR_DIG0  = 9'd508;

  localparam int unsigned DEB_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RB,
    S_RL,
    S_RH,
    S_CAP,
    S_UPD,
    S_WL,
    S_WH,
    S_D0,
    S_D1,
    S_D2,
    S_D3
  } scan_state_t;

  function automatic logic [8:0] dig_addr(input logic [1:0] idx);
    return ADDR_DIG0 + {7'd0, idx};
  endfunction

endpackage

// File: rtl/gpio_scanner_if.sv
// Bus between the scanner (master) and the memory-mapped GPIO block (slave).
interface gpio_scanner_if;
  logic       rw_select;
  logic [8:0] address;
  logic [7:0] data_out;
  logic [7:0] data_in;

  modport master (
    output rw_select,
    output address,
    output data_out,
    input  data_in
  );

  modport slave (
    input  rw_select,
    input  address,
    input  data_out,
    output data_in
  );
endinterface

// File: rtl/gpio_scanner_debounce.sv
// One-bit scan-rate debouncer; rise pulses combinationally in the step that flips stable to 1.
module button_debounce
  import gpio_map_pkg::*;
#(
  parameter int unsigned DEB_SCANS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [DEB_W-1:0] LP_LAST = DEB_W'(DEB_SCANS - 1);

  logic [DEB_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_flip;

  assign w_flip = step && (raw != r_stable) && (r_cnt == LP_LAST);
  assign stable = r_stable;
  assign rise   = w_flip && !r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (step) begin
      if (raw == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_scanner.sv
// GPIO bus master: periodically reads buttons/switches, keeps a button-driven
// counter, mirrors switches to LEDs and writes the counter to four digit registers.
module gpio_scanner
  import gpio_map_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned DEB_SCANS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_scanner_if.master         bus,
  output logic [15:0]            count,
  output logic                   scan_done
);

  localparam int unsigned     PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          w_tick;

  scan_state_t   r_state;
  logic          r_rw;
  logic [8:0]    r_addr;
  logic [7:0]    r_dout;
  logic          r_scan_done;
  logic [3:0]    r_btn_raw;
  logic [15:0]   r_sw;
  logic [15:0]   r_count;

  logic          w_step;
  logic [3:0]    w_btn_stable;
  logic [3:0]    w_rise;
  logic          w_unused;

  assign w_tick   = (r_pre == PRE_LAST);
  assign w_step   = (r_state == S_UPD);
  assign w_unused = ^w_btn_stable;

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    button_debounce #(
      .DEB_SCANS (DEB_SCANS)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .step   (w_step),
      .raw    (r_btn_raw[g]),
      .stable (w_btn_stable[g]),
      .rise   (w_rise[g])
    );
  end

  // Bus outputs are loaded on each transition with the values of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_scan_done <= 1'b0;
      r_btn_raw   <= '0;
      r_sw        <= '0;
      r_count     <= '0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_RB;
            r_addr  <= ADDR_BTN;
          end
        end
        S_RB: begin
          r_state <= S_RL;
          r_addr  <= ADDR_SW_L;
        end
        S_RL: begin
          r_btn_raw <= bus.data_in[3:0];
          r_state   <= S_RH;
          r_addr    <= ADDR_SW_H;
        end
        S_RH: begin
          r_sw[7:0] <= bus.data_in;
          r_state   <= S_CAP;
          r_addr    <= ADDR_SW_H;
        end
        S_CAP: begin
          r_sw[15:8] <= bus.data_in;
          r_state    <= S_UPD;
          r_addr     <= '0;
        end
        S_UPD: begin
          // Single action per scan; lower-priority events are dropped.
          if (w_rise[2]) begin
            r_count <= '0;
          end else if (w_rise[3]) begin
            r_count <= r_sw;
          end else if (w_rise[0]) begin
            r_count <= r_count + 16'd1;
          end else if (w_rise[1]) begin
            r_count <= r_count - 16'd1;
          end
          r_state <= S_WL;
          r_rw    <= 1'b1;
          r_addr  <= ADDR_LED_L;
          r_dout  <= r_sw[7:0];
        end
        S_WL: begin
          r_state <= S_WH;
          r_addr  <= ADDR_LED_H;
          r_dout  <= r_sw[15:8];
        end
        S_WH: begin
          r_state <= S_D0;
          r_addr  <= dig_addr(2'd0);
          r_dout  <= {4'b0, r_count[3:0]};
        end
        S_D0: begin
          r_state <= S_D1;
          r_addr  <= dig_addr(2'd1);
          r_dout  <= {4'b0, r_count[7:4]};
        end
        S_D1: begin
          r_state <= S_D2;
          r_addr  <= dig_addr(2'd2);
          r_dout  <= {4'b0, r_count[11:8]};
        end
        S_D2: begin
          r_state <= S_D3;
          r_addr  <= dig_addr(2'd3);
          r_dout  <= {4'b0, r_count[15:12]};
        end
        S_D3: begin
          r_state     <= S_IDLE;
          r_rw        <= 1'b0;
          r_addr      <= '0;
          r_dout      <= '0;
          r_scan_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_rw    <= 1'b0;
          r_addr  <= '0;
          r_dout  <= '0;
        end
      endcase
    end
  end

  assign bus.rw_select = r_rw;
  assign bus.address   = r_addr;
  assign bus.data_out  = r_dout;
  assign count         = r_count;
  assign scan_done     = r_scan_done;

endmodule

// File: tb/tb_gpio_scanner.sv
// Directed bench for gpio_scanner against a behavioural model of the GPIO memory block.
module tb_gpio_scanner;
  import gpio_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] count;
  logic        scan_done;
  logic [3:0]  btn_pin;
  logic [15:0] sw_pin;

  always #5 clk = ~clk;

  gpio_scanner_if u_bus ();

  gpio_scanner #(
    .SCAN_DIV  (16),
    .DEB_SCANS (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_bus),
    .count     (count),
    .scan_done (scan_done)
  );

  // GPIO block model: pins land in memory one cycle late, registered read data.
  logic [7:0]  mem [0:511];
  int unsigned bad_wr = 0;
  int unsigned dig_wr = 0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    u_bus.data_in = 8'h00;
  end

  always @(posedge clk) begin
    mem[ADDR_BTN]  <= {4'b0, btn_pin};
    mem[ADDR_SW_L] <= sw_pin[7:0];
    mem[ADDR_SW_H] <= sw_pin[15:8];
    if (u_bus.rw_select) begin
      if (u_bus.address >= ADDR_BTN && u_bus.address <= ADDR_SW_H)
        bad_wr <= bad_wr + 1;
      else
        mem[u_bus.address] <= u_bus.data_out;
      if (u_bus.address >= ADDR_DIG0)
        dig_wr <= dig_wr + 1;
    end
    u_bus.data_in <= mem[u_bus.address];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_scan(input int unsigned n);
    bit seen;
    for (int unsigned k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int unsigned c = 0; c < 64 && !seen; c++) begin
        @(negedge clk);
        seen = scan_done;
      end
      check("scan_done_seen", {31'd0, seen}, 32'd1);
    end
  endtask

  task automatic press(input logic [3:0] m);
    btn_pin = m;
    wait_scan(3);
    btn_pin = 4'h0;
    wait_scan(3);
  endtask

  task automatic check_digits(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_dig%0d", tag, i), {24'd0, mem[int'(ADDR_DIG0) + i]},
            {28'd0, exp[4*i +: 4]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, {16'd0, count}, 32'd0);
    check({tag, "_rw"}, {31'd0, u_bus.rw_select}, 32'd0);
    check({tag, "_addr"}, {23'd0, u_bus.address}, 32'd0);
    check({tag, "_dout"}, {24'd0, u_bus.data_out}, 32'd0);
    check({tag, "_done"}, {31'd0, scan_done}, 32'd0);
  endtask

  initial begin
    int last;
    int period;
    int unsigned n;
    int unsigned d0;
    bit found;

    btn_pin = 4'h0;
    sw_pin  = 16'hA5C3;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    last   = -1;
    period = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (scan_done) begin
        if (last >= 0) period = cyc - last;
        last = cyc;
      end
    end
    check("scan_period", period, 32'd16);
    check("led_lo", {24'd0, mem[ADDR_LED_L]}, 32'hC3);
    check("led_hi", {24'd0, mem[ADDR_LED_H]}, 32'hA5);
    check_digits("idle", 16'h0000);
    check("ro_writes_idle", bad_wr, 32'd0);

    wait_scan(1);
    press(4'b0001);
    check("inc_once", {16'd0, count}, 32'h0001);
    check_digits("inc_once", 16'h0001);

    for (int i = 0; i < 15; i++) press(4'b0001);
    check("inc_16", {16'd0, count}, 32'h0010);
    check_digits("inc_16", 16'h0010);

    press(4'b0100);
    check("clear_pre_dec", {16'd0, count}, 32'h0000);
    press(4'b0010);
    check("dec_wrap", {16'd0, count}, 32'hFFFF);
    check_digits("dec_wrap", 16'hFFFF);

    btn_pin = 4'b0001;
    wait_scan(1);
    btn_pin = 4'h0;
    wait_scan(3);
    check("glitch", {16'd0, count}, 32'hFFFF);

    sw_pin = 16'h1234;
    press(4'b1001);
    check("load_wins", {16'd0, count}, 32'h1234);
    check_digits("load_wins", 16'h1234);
    check("led_lo_1234", {24'd0, mem[ADDR_LED_L]}, 32'h34);
    check("led_hi_1234", {24'd0, mem[ADDR_LED_H]}, 32'h12);

    press(4'b0100);
    check("clear", {16'd0, count}, 32'h0000);
    check_digits("clear", 16'h0000);

    press(4'b0001);
    check("pre_reset_inc", {16'd0, count}, 32'h0001);

    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      found = u_bus.rw_select && (u_bus.address == ADDR_LED_H);
    end
    check("found_wh", {31'd0, found}, 32'd1);
    d0  = dig_wr;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midscan");
    rst = 1'b0;
    n     = 0;
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      n++;
      found = (u_bus.address == ADDR_BTN);
    end
    check("restart_delay", n, 32'd16);
    check("no_digit_writes", dig_wr - d0, 32'd0);
    check("dig0_retained", {24'd0, mem[ADDR_DIG0]}, 32'h01);
    wait_scan(1);
    check_digits("post_reset", 16'h0000);
    check("ro_writes_final", bad_wr, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
